// File: rtl/output_signature_compactor.sv
// output_signature_compactor: MISR compaction of a wide DUT output bus with a warm-up/compact/done sequencer
module output_signature_compactor #(
    parameter int                   WIDTH     = 64,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = 32'h04C11DB7,
    parameter logic [SIG_WIDTH-1:0] SEED      = 32'hFFFFFFFF,
    parameter int                   WARMUP    = 16,
    parameter int                   SAMPLES   = 1024,
    parameter logic [SIG_WIDTH-1:0] GOLDEN    = 32'h00000000,
    localparam int                  CW        = $clog2(SAMPLES + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 clear_i,
    input  logic [WIDTH-1:0]     data_in_i,
    input  logic                 data_valid_i,
    output logic [SIG_WIDTH-1:0] signature_o,
    output logic [CW-1:0]        sample_count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o
);
    localparam int             WW    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CW-1:0]  LAST  = CW'(SAMPLES);
    localparam logic [WW-1:0]  WLAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_COMPACT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d, fold, step;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    // XOR-fold the bus into one signature-wide word and form the next MISR value
    always_comb begin
        fold = '0;
        for (int i = 0; i < WIDTH / SIG_WIDTH; i++) fold = fold ^ data_in_i[i*SIG_WIDTH +: SIG_WIDTH];
        step = {sig_q[SIG_WIDTH-2:0], 1'b0} ^ (sig_q[SIG_WIDTH-1] ? POLY : '0) ^ fold;
    end

    // Sequencer next state; clear overrides everything, start only acts from IDLE or DONE
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        if (clear_i) begin
            state_d = S_IDLE;
            sig_d   = SEED;
            cnt_d   = '0;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start_i) begin
                    state_d = (WARMUP > 0) ? S_WARM : S_COMPACT;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                end
                S_WARM: if (wcnt_q == WLAST) state_d = S_COMPACT;
                        else wcnt_d = wcnt_q + WW'(1);
                S_COMPACT: if (data_valid_i) begin
                    sig_d   = step;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q + CW'(1) == LAST) ? S_DONE : S_COMPACT;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_WARM) || (state_d == S_COMPACT);
        done_d = state_d == S_DONE;
        pass_d = done_d && (sig_d == GOLDEN);
    end

    // State and registered outputs, async active-low reset to the seed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign signature_o    = sig_q;
    assign sample_count_o = cnt_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
endmodule

// File: tb/tb_output_signature_compactor.sv
// tb_output_signature_compactor: scoreboard bench for the MISR signature compactor
module tb_output_signature_compactor;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 0, rst_n = 0, start = 0, clear = 0, valid = 0;
    logic [63:0] data = '0;

    logic [31:0] sig_a, sig_b, sig_c, sig_d, sig_e;
    logic [10:0] cnt_a;
    logic [0:0]  cnt_b, cnt_c, cnt_d;
    logic [2:0]  cnt_e;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
    logic busy_d, done_d, pass_d, busy_e, done_e, pass_e;

    int passed = 0, total = 0;
    logic [31:0] q[$];
    logic [63:0] dq[$];

    always #5 clk = ~clk;

    output_signature_compactor u_a (.clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
        .data_in_i(data), .data_valid_i(valid), .signature_o(sig_a), .sample_count_o(cnt_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a));
    output_signature_compactor #(.WARMUP(0), .SAMPLES(1)) u_b (.clk_i(clk), .rst_ni(rst_n),
        .start_i(start), .clear_i(clear), .data_in_i(data), .data_valid_i(valid), .signature_o(sig_b),
        .sample_count_o(cnt_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b));
    output_signature_compactor #(.SEED(32'h0), .WARMUP(0), .SAMPLES(1), .GOLDEN(32'h1)) u_c (.clk_i(clk),
        .rst_ni(rst_n), .start_i(start), .clear_i(clear), .data_in_i(data), .data_valid_i(valid),
        .signature_o(sig_c), .sample_count_o(cnt_c), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c));
    output_signature_compactor #(.SEED(32'h0), .WARMUP(0), .SAMPLES(1), .GOLDEN(32'h0)) u_d (.clk_i(clk),
        .rst_ni(rst_n), .start_i(start), .clear_i(clear), .data_in_i(data), .data_valid_i(valid),
        .signature_o(sig_d), .sample_count_o(cnt_d), .busy_o(busy_d), .done_o(done_d), .pass_o(pass_d));
    output_signature_compactor #(.WARMUP(16), .SAMPLES(4)) u_e (.clk_i(clk), .rst_ni(rst_n),
        .start_i(start), .clear_i(clear), .data_in_i(data), .data_valid_i(valid), .signature_o(sig_e),
        .sample_count_o(cnt_e), .busy_o(busy_e), .done_o(done_e), .pass_o(pass_e));

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [63:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ d[63:32] ^ d[31:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear;
        clear = 1; start = 0; valid = 0;
        tick();
        clear = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom); clear = 1'($urandom); valid = 1'($urandom); data = {$urandom, $urandom};
            tick();
        end
        total += 6;
        if (sig_a !== SEED) $display("FAIL reset_sig got %h want %h", sig_a, SEED); else passed++;
        if (cnt_a !== 11'd0) $display("FAIL reset_cnt got %0d want 0", cnt_a); else passed++;
        if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else passed++;
        if (done_a !== 1'b0) $display("FAIL reset_done got %b want 0", done_a); else passed++;
        if (pass_a !== 1'b0) $display("FAIL reset_pass got %b want 0", pass_a); else passed++;
        if (sig_e !== SEED) $display("FAIL reset_sig_e got %h want %h", sig_e, SEED); else passed++;
        start = 0; clear = 0; valid = 0; data = '0;
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_sample;
        do_clear();
        data = '0; valid = 1; start = 1;
        tick();
        start = 0;
        total += 3;
        if (busy_b !== 1'b1) $display("FAIL single_busy got %b want 1", busy_b); else passed++;
        if (cnt_b !== 1'd0) $display("FAIL single_cnt0 got %0d want 0", cnt_b); else passed++;
        if (done_b !== 1'b0) $display("FAIL single_done0 got %b want 0", done_b); else passed++;
        tick();
        total += 5;
        if (sig_b !== 32'hFB3EE249) $display("FAIL single_sig got %h want fb3ee249", sig_b); else passed++;
        if (cnt_b !== 1'd1) $display("FAIL single_cnt got %0d want 1", cnt_b); else passed++;
        if (done_b !== 1'b1) $display("FAIL single_done got %b want 1", done_b); else passed++;
        if (busy_b !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy_b); else passed++;
        if (pass_b !== 1'b0) $display("FAIL single_pass got %b want 0", pass_b); else passed++;
        data = {$urandom, $urandom};
        tick();
        total += 2;
        if (sig_b !== 32'hFB3EE249) $display("FAIL done_hold_sig got %h want fb3ee249", sig_b); else passed++;
        if (cnt_b !== 1'd1) $display("FAIL done_hold_cnt got %0d want 1", cnt_b); else passed++;
        valid = 0;
    endtask

    task automatic test_golden;
        do_clear();
        data = 64'h00000001_00000000; valid = 1; start = 1;
        tick();
        start = 0;
        tick();
        valid = 0;
        total += 6;
        if (sig_c !== 32'h1) $display("FAIL golden_sig_c got %h want 00000001", sig_c); else passed++;
        if (pass_c !== 1'b1) $display("FAIL golden_pass_c got %b want 1", pass_c); else passed++;
        if (done_c !== 1'b1) $display("FAIL golden_done_c got %b want 1", done_c); else passed++;
        if (sig_d !== 32'h1) $display("FAIL golden_sig_d got %h want 00000001", sig_d); else passed++;
        if (pass_d !== 1'b0) $display("FAIL golden_pass_d got %b want 0", pass_d); else passed++;
        if (done_d !== 1'b1) $display("FAIL golden_done_d got %b want 1", done_d); else passed++;
    endtask

    task automatic test_warmup_toggle;
        logic [31:0] m, e;
        int mc;
        do_clear();
        start = 1; valid = 1;
        tick();
        start = 0;
        for (int i = 0; i < 16; i++) begin
            valid = 1'($urandom); data = {$urandom, $urandom};
            tick();
            total += 3;
            if (sig_e !== SEED) $display("FAIL warm_sig[%0d] got %h want %h", i, sig_e, SEED); else passed++;
            if (cnt_e !== 3'd0) $display("FAIL warm_cnt[%0d] got %0d want 0", i, cnt_e); else passed++;
            if (busy_e !== 1'b1) $display("FAIL warm_busy[%0d] got %b want 1", i, busy_e); else passed++;
        end
        m = SEED; mc = 0;
        for (int i = 0; i < 40 && mc < 4; i++) begin
            valid = (i % 2 == 0); data = {$urandom, $urandom};
            if (valid) begin
                m = misr(m, data); mc++;
                q.push_back(m);
            end
            tick();
            e = valid ? q.pop_front() : m;
            total += 3;
            if (sig_e !== e) $display("FAIL compact_sig[%0d] got %h want %h", i, sig_e, e); else passed++;
            if (int'(cnt_e) !== mc) $display("FAIL compact_cnt[%0d] got %0d want %0d", i, cnt_e, mc); else passed++;
            if (done_e !== (mc == 4)) $display("FAIL compact_done[%0d] got %b want %b", i, done_e, mc == 4); else passed++;
        end
        valid = 0;
        total += 2;
        if (mc != 4) $display("FAIL compact_timeout got %0d samples want 4", mc); else passed++;
        if (pass_e !== (m == 32'h0)) $display("FAIL compact_pass got %b want %b", pass_e, m == 32'h0); else passed++;
    endtask

    task automatic test_clear_start;
        logic [31:0] m, e;
        do_clear();
        start = 1;
        tick();
        start = 0;
        repeat (16) tick();
        m = SEED;
        for (int i = 0; i < 5; i++) begin
            valid = 1; data = {$urandom, $urandom};
            m = misr(m, data); q.push_back(m);
            tick();
            e = q.pop_front();
            total++;
            if (sig_a !== e) $display("FAIL cs_sig[%0d] got %h want %h", i, sig_a, e); else passed++;
        end
        valid = 0; start = 1;
        tick();
        total += 3;
        if (sig_a !== m) $display("FAIL busy_start_sig got %h want %h", sig_a, m); else passed++;
        if (cnt_a !== 11'd5) $display("FAIL busy_start_cnt got %0d want 5", cnt_a); else passed++;
        if (busy_a !== 1'b1) $display("FAIL busy_start_busy got %b want 1", busy_a); else passed++;
        clear = 1; start = 1; valid = 1;
        tick();
        clear = 0; start = 0; valid = 0;
        total += 4;
        if (sig_a !== SEED) $display("FAIL clear_sig got %h want %h", sig_a, SEED); else passed++;
        if (cnt_a !== 11'd0) $display("FAIL clear_cnt got %0d want 0", cnt_a); else passed++;
        if (busy_a !== 1'b0) $display("FAIL clear_busy got %b want 0", busy_a); else passed++;
        if (done_a !== 1'b0) $display("FAIL clear_done got %b want 0", done_a); else passed++;
        tick();
        total++;
        if (busy_a !== 1'b0) $display("FAIL clear_stays_idle got %b want 0", busy_a); else passed++;
    endtask

    task automatic test_reset_restart;
        logic [31:0] m, e, final1;
        int mc, cyc;
        do_clear();
        start = 1;
        tick();
        start = 0;
        repeat (16) tick();
        valid = 1;
        repeat (100) begin
            data = {$urandom, $urandom};
            tick();
        end
        valid = 0;
        #2 rst_n = 0;
        #1;
        total += 3;
        if (sig_a !== SEED) $display("FAIL async_rst_sig got %h want %h", sig_a, SEED); else passed++;
        if (cnt_a !== 11'd0) $display("FAIL async_rst_cnt got %0d want 0", cnt_a); else passed++;
        if (busy_a !== 1'b0) $display("FAIL async_rst_busy got %b want 0", busy_a); else passed++;
        tick();
        rst_n = 1;
        tick();
        start = 1;
        tick();
        start = 0;
        repeat (16) tick();
        m = SEED; mc = 0; cyc = 0;
        dq.delete();
        while (mc < 1024 && cyc < 3000) begin
            valid = ($urandom % 4 != 0); data = {$urandom, $urandom};
            if (valid) begin
                m = misr(m, data); mc++;
                q.push_back(m); dq.push_back(data);
            end
            tick();
            cyc++;
            if (valid) begin
                e = q.pop_front();
                total += 2;
                if (sig_a !== e) $display("FAIL run_sig[%0d] got %h want %h", mc, sig_a, e); else passed++;
                if (int'(cnt_a) !== mc) $display("FAIL run_cnt[%0d] got %0d want %0d", mc, cnt_a, mc); else passed++;
            end
        end
        valid = 0;
        final1 = m;
        total += 3;
        if (mc != 1024) $display("FAIL run_timeout got %0d samples want 1024", mc); else passed++;
        if (done_a !== 1'b1) $display("FAIL run_done got %b want 1", done_a); else passed++;
        if (pass_a !== (m == 32'h0)) $display("FAIL run_pass got %b want %b", pass_a, m == 32'h0); else passed++;
        start = 1;
        tick();
        start = 0;
        total++;
        if (sig_a !== SEED) $display("FAIL restart_seed got %h want %h", sig_a, SEED); else passed++;
        repeat (16) tick();
        valid = 1;
        foreach (dq[i]) begin
            data = dq[i];
            tick();
        end
        valid = 0;
        total += 3;
        if (sig_a !== final1) $display("FAIL replay_sig got %h want %h", sig_a, final1); else passed++;
        if (cnt_a !== 11'd1024) $display("FAIL replay_cnt got %0d want 1024", cnt_a); else passed++;
        if (done_a !== 1'b1) $display("FAIL replay_done got %b want 1", done_a); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_golden();
        test_warmup_toggle();
        test_clear_start();
        test_reset_restart();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
